// File: rtl/walk_service_controller_pkg.sv
// traffic_pkg: phase states and default timing shared by the walk service controller.
package traffic_pkg;
    typedef enum logic [2:0] {IDLE, REQ, WALK, FLASH, CLEAR, LOCKOUT} state_t;
    localparam int TW_DEF = 8;
    localparam logic [7:0] WALK_TIME_DEF = 8'd10;
    localparam logic [7:0] FLASH_TIME_DEF = 8'd6;
    localparam logic [7:0] CLEAR_TIME_DEF = 8'd2;
    localparam logic [7:0] MIN_GAP_DEF = 8'd20;
endpackage

// File: rtl/walk_service_controller_if.sv
// walk_service_controller_if: request-latch, main-road and lamp signals of the walk controller.
interface walk_service_controller_if;
    logic Tick, WR, Main_Safe;
    logic WR_Reset, Main_Hold, Walk_Lamp, DontWalk_Lamp, Fault;
    modport master (output Tick, WR, Main_Safe, input WR_Reset, Main_Hold, Walk_Lamp, DontWalk_Lamp, Fault);
    modport slave (input Tick, WR, Main_Safe, output WR_Reset, Main_Hold, Walk_Lamp, DontWalk_Lamp, Fault);
endinterface

// File: rtl/walk_service_controller_phase_timer.sv
// phase_timer: loadable down-counter advanced by Tick; Done flags the last counted tick of a phase.
module phase_timer #(
    parameter int TW = 8
) (
    input  logic          Clk,
    input  logic          Reset_n,
    input  logic          Load,
    input  logic [TW-1:0] Value,
    input  logic          Tick,
    output logic          Done
);
    logic [TW-1:0] count;
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) count <= '0;
        else if (Load) count <= Value;
        else if (Tick && count != '0) count <= count - TW'(1);
    end
    assign Done = Tick && count == TW'(1);
endmodule

// File: rtl/walk_service_controller.sv
// walk_service_controller: services latched walk requests by holding the main road and sequencing
// the walk, flash and clearance lamps, followed by a lockout gap.
module walk_service_controller
    import traffic_pkg::*;
#(
    parameter int          TW         = TW_DEF,
    parameter logic [TW-1:0] WALK_TIME  = TW'(WALK_TIME_DEF),
    parameter logic [TW-1:0] FLASH_TIME = TW'(FLASH_TIME_DEF),
    parameter logic [TW-1:0] CLEAR_TIME = TW'(CLEAR_TIME_DEF),
    parameter logic [TW-1:0] MIN_GAP    = TW'(MIN_GAP_DEF)
) (
    input logic Clk,
    input logic Reset_n,
    walk_service_controller_if.slave bus
);
    state_t state, state_next;
    logic load, done;
    logic [TW-1:0] load_value;
    logic wr_reset_q, hold_q, walk_q, dw_q, fault_q;
    logic wr_reset_d, hold_d, walk_d, dw_d, fault_d;
    logic released;

    phase_timer #(.TW(TW)) timer (
        .Clk(Clk), .Reset_n(Reset_n), .Load(load), .Value(load_value), .Tick(bus.Tick), .Done(done)
    );

    // Losing Main_Safe while pedestrians are released overrides any phase timing.
    assign released = state == WALK || state == FLASH;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.WR) state_next = REQ;
            REQ:     if (bus.Main_Safe) state_next = WALK;
            WALK:    if (!bus.Main_Safe) state_next = CLEAR; else if (done) state_next = FLASH;
            FLASH:   if (!bus.Main_Safe || done) state_next = CLEAR;
            CLEAR:   if (done) state_next = LOCKOUT;
            LOCKOUT: if (done) state_next = IDLE;
            default: state_next = IDLE;
        endcase
        load = state_next != state;
        load_value = state_next == WALK ? WALK_TIME :
                     state_next == FLASH ? FLASH_TIME :
                     state_next == CLEAR ? CLEAR_TIME : MIN_GAP;
        hold_d = state_next inside {REQ, WALK, FLASH, CLEAR};
        walk_d = state_next == WALK;
        dw_d = (state_next == FLASH && state == FLASH) ? dw_q ^ bus.Tick : state_next != WALK;
        wr_reset_d = state_next == WALK && state != WALK;
        fault_d = fault_q || (released && !bus.Main_Safe);
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= IDLE;
            wr_reset_q <= 1'b0;
            hold_q <= 1'b0;
            walk_q <= 1'b0;
            dw_q <= 1'b1;
            fault_q <= 1'b0;
        end else begin
            state <= state_next;
            wr_reset_q <= wr_reset_d;
            hold_q <= hold_d;
            walk_q <= walk_d;
            dw_q <= dw_d;
            fault_q <= fault_d;
        end
    end

    assign bus.WR_Reset = wr_reset_q;
    assign bus.Main_Hold = hold_q;
    assign bus.Walk_Lamp = walk_q;
    assign bus.DontWalk_Lamp = dw_q;
    assign bus.Fault = fault_q;
endmodule

// File: tb/tb_walk_service_controller.sv
// tb_walk_service_controller: scoreboard bench; a tick-counting reference model queues expected
// outputs every clock and the negedge monitor compares them, alongside directed timing checks.
module tb_walk_service_controller;
    import traffic_pkg::*;
    localparam logic [7:0] RST_VEC = 8'h02;
    localparam int B_FAULT = 0, B_DW = 1, B_WALK = 2, B_HOLD = 3, B_WRR = 4;
    localparam int WT = 4, FT = 3, CT = 2, GT = 5;

    logic Clk = 1'b0;
    logic Reset_n = 1'b0;
    walk_service_controller_if bus();

    walk_service_controller #(
        .TW(8), .WALK_TIME(8'd4), .FLASH_TIME(8'd3), .CLEAR_TIME(8'd2), .MIN_GAP(8'd5)
    ) dut (
        .Clk(Clk), .Reset_n(Reset_n), .bus(bus)
    );

    always #5 Clk = ~Clk;

    int n_checks = 0, n_fail = 0, n_wrr = 0, tdiv = 0;
    logic clr = 1'b0, auto_clr = 1'b1, tick_high = 1'b0;
    logic [7:0] sb[$];
    state_t m_state = IDLE;
    int m_cnt = 0;
    logic m_dw = 1'b1, m_fault = 1'b0, m_wrr = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] outs();
        return {3'b0, bus.WR_Reset, bus.Main_Hold, bus.Walk_Lamp, bus.DontWalk_Lamp, bus.Fault};
    endfunction

    function automatic int phase_len(input state_t s);
        return s == WALK ? WT : s == FLASH ? FT : s == CLEAR ? CT : GT;
    endfunction

    function automatic state_t next_of(input state_t s);
        return s == WALK ? FLASH : s == FLASH ? CLEAR : s == CLEAR ? LOCKOUT : IDLE;
    endfunction

    task automatic m_go(input state_t s);
        m_state = s;
        m_cnt = 0;
        m_dw = s != WALK;
        m_wrr = s == WALK;
    endtask

    task automatic m_reset();
        m_state = IDLE;
        m_cnt = 0;
        m_dw = 1'b1;
        m_fault = 1'b0;
        m_wrr = 1'b0;
        sb.delete();
    endtask

    task automatic m_tick();
        if (bus.Tick) begin
            m_cnt++;
            if (m_cnt == phase_len(m_state)) m_go(next_of(m_state));
            else if (m_state == FLASH) m_dw = !m_dw;
        end
    endtask

    // Reference model: counts ticks upward per phase and queues the expected output vector.
    always @(posedge Clk) begin
        if (Reset_n) begin
            m_wrr = 1'b0;
            case (m_state)
                IDLE: if (bus.WR) m_go(REQ);
                REQ:  if (bus.Main_Safe) m_go(WALK);
                WALK, FLASH: begin
                    if (!bus.Main_Safe) begin
                        m_fault = 1'b1;
                        m_go(CLEAR);
                    end else m_tick();
                end
                default: m_tick();
            endcase
            sb.push_back({3'b0, m_wrr, m_state inside {REQ, WALK, FLASH, CLEAR}, m_state == WALK, m_dw, m_fault});
        end
    end

    always @(negedge Clk) begin
        if (!Reset_n) check("reset_outs", outs(), RST_VEC);
        else if (sb.size() > 0) check("scoreboard", outs(), sb.pop_front());
        if (Reset_n && bus.WR_Reset) begin
            clr = 1'b1;
            n_wrr++;
        end
    end

    // Tick source and the request latch that WR_Reset clears.
    always @(posedge Clk) begin
        #2;
        tdiv = (tdiv + 1) % 4;
        bus.Tick = tick_high || tdiv == 0;
        if (clr && auto_clr) bus.WR = 1'b0;
        clr = 1'b0;
    end

    task automatic wait_out(input string tag, input int b, input logic v, input int max, output int n);
        logic [7:0] o;
        for (n = 1; n <= max; n++) begin
            @(negedge Clk);
            o = outs();
            if (o[b] == v) return;
        end
        check({tag, "_timeout"}, n, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    initial begin
        int n, k, last, wrr_before;
        logic prev_dw, relatched;
        logic [4:0] dw_seq;
        bus.Tick = 1'b0;
        bus.WR = 1'b0;
        bus.Main_Safe = 1'b0;
        m_reset();
        repeat (3) @(negedge Clk);
        #1 Reset_n = 1'b1;

        repeat (50) @(negedge Clk);
        check("idle_outs", outs(), RST_VEC);

        bus.WR = 1'b1;
        wait_out("hold_rise", B_HOLD, 1'b1, 10, n);
        check("hold_rise_lat", n, 1);
        repeat (3) @(negedge Clk);
        bus.Main_Safe = 1'b1;
        wait_out("walk_rise", B_WALK, 1'b1, 10, n);
        check("walk_rise_lat", n, 1);
        check("wrr_with_walk", bus.WR_Reset, 1);

        k = 0;
        n = 0;
        prev_dw = 1'b0;
        relatched = 1'b0;
        for (int i = 0; i < 300 && bus.Main_Hold; i++) begin
            if (bus.Walk_Lamp && bus.Tick) k++;
            if (bus.Walk_Lamp && !bus.WR_Reset && !bus.WR && !relatched) begin
                bus.WR = 1'b1;
                relatched = 1'b1;
            end
            @(negedge Clk);
            if (bus.DontWalk_Lamp != prev_dw && !bus.Walk_Lamp && bus.Main_Hold) n++;
            prev_dw = bus.DontWalk_Lamp;
        end
        check("hold_fall", bus.Main_Hold, 0);
        check("walk_ticks", k, WT);
        check("flash_toggles", n, 3);
        check("relatched", relatched, 1);

        k = 0;
        last = 0;
        for (n = 0; n < 200 && !bus.Main_Hold; n++) begin
            if (bus.Tick) begin
                k++;
                last = n;
            end
            @(negedge Clk);
        end
        check("lockout_ticks", k, GT);
        check("lockout_tail", n - last, 2);
        check("single_wrr", n_wrr, 1);

        wait_out("walk2", B_WALK, 1'b1, 10, n);
        k = 0;
        for (int i = 0; i < 100; i++) begin
            if (bus.Walk_Lamp && bus.Tick) k++;
            if (k == 2) break;
            @(negedge Clk);
        end
        bus.Main_Safe = 1'b0;
        @(negedge Clk);
        check("fault_walk_off", bus.Walk_Lamp, 0);
        check("fault_dw_on", bus.DontWalk_Lamp, 1);
        check("fault_set", bus.Fault, 1);
        k = 0;
        for (int i = 0; i < 100 && bus.Main_Hold; i++) begin
            if (bus.Tick) k++;
            @(negedge Clk);
        end
        check("fault_clear_ticks", k, CT);
        bus.Main_Safe = 1'b1;
        bus.WR = 1'b1;
        repeat (30) @(negedge Clk);
        check("fault_sticky", bus.Fault, 1);

        wait_out("walk3", B_WALK, 1'b1, 60, n);
        wait_out("flash3", B_WALK, 1'b0, 60, n);
        check("in_flash_hold", bus.Main_Hold, 1);
        auto_clr = 1'b0;
        bus.WR = 1'b1;
        wrr_before = n_wrr;
        #1 Reset_n = 1'b0;
        m_reset();
        #1 check("rst_async", outs(), RST_VEC);
        repeat (2) @(negedge Clk);
        #1 Reset_n = 1'b1;
        auto_clr = 1'b1;
        wait_out("rst_req", B_HOLD, 1'b1, 10, n);
        check("req_after_rst", n, 1);
        check("no_wrr_in_rst", n_wrr, wrr_before);

        wait_out("lock4", B_HOLD, 1'b0, 100, n);
        tick_high = 1'b1;
        repeat (20) @(negedge Clk);
        check("idle_before_fast", outs(), RST_VEC);
        bus.WR = 1'b1;
        wait_out("walk_fast", B_WALK, 1'b1, 10, n);
        k = 0;
        for (int i = 0; i < 20 && bus.Walk_Lamp; i++) begin
            k++;
            @(negedge Clk);
        end
        check("fast_walk_cycles", k, WT);
        k = 0;
        dw_seq = '0;
        for (int i = 0; i < 20 && bus.Main_Hold; i++) begin
            dw_seq = {dw_seq[3:0], bus.DontWalk_Lamp};
            k++;
            @(negedge Clk);
        end
        check("fast_flash_clear_cycles", k, FT + CT);
        check("fast_dw_pattern", dw_seq, 5'b10111);
        k = 0;
        for (int i = 0; i < 20 && !bus.Main_Hold; i++) begin
            k++;
            @(negedge Clk);
        end
        check("fast_idle_no_hold", k, 20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
